// File: rtl/iter_shifter.sv
// Multi-cycle shift/rotate unit: moves up to STEP bits per clock until the requested
// amount is done, with valid/ready handshakes on the command and result sides.
module iter_shifter #(
  parameter int WIDTH   = 32,
  parameter int STEP    = 1,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         in_funct,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [SHAMT_W-1:0] in_n,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_r,
  output logic               busy,
  output logic [1:0]         fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
  // ready/valid are decoded from state only, so neither depends on the other side's signal.

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  localparam logic [2:0] F_SLL = 3'b000;
  localparam logic [2:0] F_SRL = 3'b001;
  localparam logic [2:0] F_ROL = 3'b010;
  localparam logic [2:0] F_SRA = 3'b011;
  localparam logic [2:0] F_ROR = 3'b100;

  localparam logic [SHAMT_W:0] WIDTH_C = (SHAMT_W+1)'(WIDTH);
  localparam logic [SHAMT_W:0] STEP_C  = (SHAMT_W+1)'(STEP);

  state_t             state, state_n;
  logic [WIDTH-1:0]   data, data_n;
  logic [SHAMT_W-1:0] rem, rem_n;
  logic [2:0]         funct_q, funct_n;
  logic               sign_q, sign_n;

  logic [SHAMT_W-1:0] n_mod;
  logic [SHAMT_W:0]   k;
  logic [SHAMT_W:0]   kc;
  logic [WIDTH-1:0]   stepped;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      data    <= '0;
      rem     <= '0;
      funct_q <= '0;
      sign_q  <= 1'b0;
    end else begin
      state   <= state_n;
      data    <= data_n;
      rem     <= rem_n;
      funct_q <= funct_n;
      sign_q  <= sign_n;
    end
  end

  // Only non-power-of-two widths can present an amount >= WIDTH; one subtract suffices.
  always_comb begin
    n_mod = in_n;
    if ({1'b0, in_n} >= WIDTH_C) n_mod = SHAMT_W'({1'b0, in_n} - WIDTH_C);
  end

  // One iteration: k = min(STEP, rem); k is never 0 while in SHIFT.
  always_comb begin
    k       = ({1'b0, rem} < STEP_C) ? {1'b0, rem} : STEP_C;
    kc      = WIDTH_C - k;
    stepped = data;
    case (funct_q)
      F_SLL:   stepped = data << k;
      F_SRL:   stepped = data >> k;
      F_ROL:   stepped = (data << k) | (data >> kc);
      F_SRA:   stepped = ({WIDTH{sign_q}} << kc) | (data >> k);
      F_ROR:   stepped = (data >> k) | (data << kc);
      default: stepped = data;
    endcase
  end

  always_comb begin
    state_n = state;
    data_n  = data;
    rem_n   = rem;
    funct_n = funct_q;
    sign_n  = sign_q;
    if (flush) begin
      state_n = IDLE;
      data_n  = '0;
      rem_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            funct_n = in_funct;
            sign_n  = in_a[WIDTH-1];
            data_n  = in_a;
            rem_n   = n_mod;
            if (n_mod == '0) begin
              state_n = DONE;
            end else if (in_funct > F_ROR) begin
              data_n  = '0;
              rem_n   = '0;
              state_n = DONE;
            end else begin
              state_n = SHIFT;
            end
          end
        end
        SHIFT: begin
          data_n = stepped;
          rem_n  = rem - k[SHAMT_W-1:0];
          if (rem_n == '0) state_n = DONE;
        end
        DONE: begin
          if (out_ready) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          data_n  = '0;
          rem_n   = '0;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == SHIFT) || (state == DONE);
  assign out_r     = (state == DONE) ? data : '0;
  assign fsm_state = state;

endmodule

// File: tb/tb_iter_shifter.sv
// Directed bench for iter_shifter: WIDTH=32 with STEP=4 (main instance) and STEP=1
// (second instance), checking results, latency, backpressure, flush and async reset.
module tb_iter_shifter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_funct = '0;
  logic [31:0] in_a = '0;
  logic [4:0]  in_n = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_r;
  logic        busy;
  logic [1:0]  fsm_state;

  logic        s1_flush = 1'b0;
  logic        s1_in_valid = 1'b0;
  logic        s1_in_ready;
  logic [2:0]  s1_in_funct = '0;
  logic [31:0] s1_in_a = '0;
  logic [4:0]  s1_in_n = '0;
  logic        s1_out_valid;
  logic        s1_out_ready = 1'b0;
  logic [31:0] s1_out_r;
  logic        s1_busy;
  logic [1:0]  s1_fsm_state;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  iter_shifter #(.WIDTH(32), .STEP(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct),
    .in_a(in_a), .in_n(in_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_r(out_r),
    .busy(busy), .fsm_state(fsm_state)
  );

  iter_shifter #(.WIDTH(32), .STEP(1)) u_dut_s1 (
    .clk(clk), .rst_n(rst_n), .flush(s1_flush),
    .in_valid(s1_in_valid), .in_ready(s1_in_ready), .in_funct(s1_in_funct),
    .in_a(s1_in_a), .in_n(s1_in_n),
    .out_valid(s1_out_valid), .out_ready(s1_out_ready), .out_r(s1_out_r),
    .busy(s1_busy), .fsm_state(s1_fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one command, wait for the result, optionally stall the consumer, then drain.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [4:0] n, input logic [31:0] exp_r, input int exp_lat,
                        input int hold);
    int lat;
    logic busy_ok;
    logic [31:0] exp;
    exp_q.push_back(exp_r);
    @(negedge clk);
    check({tag, "/in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_funct = f; in_a = a; in_n = n;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_a     = $urandom;
    in_n     = 5'($urandom_range(0, 31));
    in_funct = 3'($urandom_range(0, 7));
    lat = 1;
    busy_ok = 1'b1;
    while (!out_valid && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/busy"}, 32'(busy_ok), 32'd1);
    check({tag, "/out_r"}, out_r, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_r"}, out_r, exp);
      check({tag, "/hold_in_ready"}, 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/drain_in_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic seen;
    repeat (2) @(posedge clk);
    #1;
    check("rst/out_r", out_r, 32'h0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("sll31",   3'b000, 32'h0000_0001, 5'd31, 32'h8000_0000, 9, 0);
    run_op("sra4",    3'b011, 32'h8000_0000, 5'd4,  32'hF800_0000, 2, 0);
    run_op("ror4",    3'b100, 32'h0000_00F1, 5'd4,  32'h1000_000F, 2, 0);
    run_op("rol1",    3'b010, 32'h8000_0001, 5'd1,  32'h0000_0003, 2, 0);
    run_op("srl0",    3'b001, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1, 0);
    run_op("illegal", 3'b110, 32'h1234_5678, 5'd5,  32'h0000_0000, 1, 0);
    run_op("srl31",   3'b001, 32'h8000_0000, 5'd31, 32'h0000_0001, 9, 0);
    run_op("rol8",    3'b010, 32'h1234_5678, 5'd8,  32'h3456_7812, 3, 0);
    run_op("ror12",   3'b100, 32'h1234_5678, 5'd12, 32'h6781_2345, 4, 0);
    run_op("sra3pos", 3'b011, 32'h7FFF_FFFF, 5'd3,  32'h0FFF_FFFF, 2, 0);
    run_op("sll5bp",  3'b000, 32'hDEAD_BEEF, 5'd5,  32'hD5B7_DDE0, 3, 5);
    run_op("b2b",     3'b001, 32'hF000_0000, 5'd7,  32'h01E0_0000, 3, 0);

    // STEP=1 instance: worst-case arithmetic shift
    @(negedge clk);
    s1_in_valid = 1'b1; s1_in_funct = 3'b011; s1_in_a = 32'h8000_0000; s1_in_n = 5'd31;
    @(posedge clk); #1;
    s1_in_valid = 1'b0;
    lat = 1;
    while (!s1_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s1_sra31/latency", 32'(lat), 32'd32);
    check("s1_sra31/out_r", s1_out_r, 32'hFFFF_FFFF);
    @(negedge clk);
    s1_out_ready = 1'b1;
    @(posedge clk); #1;
    s1_out_ready = 1'b0;
    check("s1_sra31/drain_valid", 32'(s1_out_valid), 32'd0);

    // Flush mid-SHIFT, with a competing command in the same cycle
    @(negedge clk);
    in_valid = 1'b1; in_funct = 3'b000; in_a = 32'h0000_0001; in_n = 5'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct = 3'b001; in_a = 32'hFFFF_FFFF; in_n = 5'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush/out_valid", 32'(out_valid), 32'd0);
    check("flush/in_ready", 32'(in_ready), 32'd1);
    check("flush/busy", 32'(busy), 32'd0);
    check("flush/out_r", out_r, 32'h0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    check("flush/no_result", 32'(seen), 32'd0);

    // Flush in IDLE blocks an in_valid on the same edge
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; in_funct = 3'b000; in_a = 32'h1; in_n = 5'd0;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_idle/busy", 32'(busy), 32'd0);
    check("flush_idle/out_valid", 32'(out_valid), 32'd0);

    // Async reset mid-SHIFT
    @(negedge clk);
    in_valid = 1'b1; in_funct = 3'b010; in_a = 32'hA5A5_0F0F; in_n = 5'd29;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst/busy", 32'(busy), 32'd0);
    check("arst/in_ready", 32'(in_ready), 32'd1);
    check("arst/out_valid", 32'(out_valid), 32'd0);
    check("arst/out_r", out_r, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    check("arst/no_result", 32'(seen), 32'd0);

    run_op("post_rst", 3'b100, 32'h0000_0001, 5'd1, 32'h8000_0000, 2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
